// File: rtl/riscv_crypto_fu_aes64_seq.sv
// Iterative AES64 unit: ShiftRows+SubBytes over two columns using SBOX_PER_CYCLE
// shared S-boxes, then optional forward/inverse MixColumn on each 32-bit word.

package riscv_crypto_aes_pkg;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    logic [7:0] m;
    p = '0;
    s = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ s;
      s = xt(s);
      m = m >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254: six square-and-multiply steps reach a^127.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    p = a;
    for (int unsigned i = 0; i < 6; i++) p = gmul(gmul(p, p), a);
    return gmul(p, p);
  endfunction

endpackage

module riscv_crypto_aes_sbox (
  input  logic [7:0] x,
  input  logic       inv,
  output logic [7:0] y
);
  import riscv_crypto_aes_pkg::*;

  logic [7:0] pre;
  logic [7:0] g;

  always_comb begin
    pre = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
    g   = ginv(pre);
    y   = inv ? g
              : (g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63);
  end
endmodule

module riscv_crypto_aes_mixcol_fwd (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  import riscv_crypto_aes_pkg::*;

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    {a3, a2, a1, a0} = col;
    mixed[7:0]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    mixed[15:8]  = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    mixed[23:16] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    mixed[31:24] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
  end
endmodule

module riscv_crypto_aes_mixcol_inv (
  input  logic [31:0] col,
  output logic [31:0] mixed
);
  import riscv_crypto_aes_pkg::*;

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    {a3, a2, a1, a0} = col;
    mixed[7:0]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    mixed[15:8]  = gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d) ^ gmul(a0, 8'h09);
    mixed[23:16] = gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b) ^ gmul(a0, 8'h0d) ^ gmul(a1, 8'h09);
    mixed[31:24] = gmul(a3, 8'h0e) ^ gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09);
  end
endmodule

module riscv_crypto_fu_aes64_seq #(
  parameter int unsigned SBOX_PER_CYCLE = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op_es,
  input  logic        op_esm,
  input  logic        op_ds,
  input  logic        op_dsm,
  input  logic        op_im,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] rd
);

  localparam int unsigned SUB_CYCLES = 8 / SBOX_PER_CYCLE;

  typedef enum logic [1:0] {ST_IDLE, ST_SUB, ST_MIX, ST_DONE} state_e;

  state_e         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           sub_inv_q, sub_inv_d;
  logic           do_mix_q, do_mix_d;
  logic           mix_inv_q, mix_inv_d;
  logic [127:0]   st_q, st_d;
  logic [63:0]    mid_q, mid_d;
  logic [63:0]    rd_q, rd_d;

  logic [4:0]     ops;
  logic           op_legal;
  logic           last_k;

  logic [8*SBOX_PER_CYCLE-1:0] sb_in, sb_out;
  logic [3*SBOX_PER_CYCLE-1:0] lane_j;
  logic [2:0]     j;
  logic [1:0]     r, c;

  logic [31:0]    fmix_lo, fmix_hi, imix_lo, imix_hi;

  assign ops      = {op_im, op_dsm, op_ds, op_esm, op_es};
  assign op_legal = $onehot(ops);
  assign last_k   = (cnt_q == 3'(SUB_CYCLES - 1));

  // Output byte j sits at row j[1:0], column j[2]; fetch its ShiftRows source byte.
  always_comb begin
    sb_in  = '0;
    lane_j = '0;
    j      = '0;
    r      = '0;
    c      = '0;
    for (int unsigned i = 0; i < SBOX_PER_CYCLE; i++) begin
      j = 3'(cnt_q * SBOX_PER_CYCLE + i);
      r = j[1:0];
      c = sub_inv_q ? ({1'b0, j[2]} - r) : ({1'b0, j[2]} + r);
      lane_j[3*i +: 3] = j;
      sb_in[8*i +: 8]  = st_q[{c, r, 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_lane
    riscv_crypto_aes_sbox u_sbox (
      .x   (sb_in[8*g +: 8]),
      .inv (sub_inv_q),
      .y   (sb_out[8*g +: 8])
    );
  end

  riscv_crypto_aes_mixcol_fwd u_fmix_lo (.col(mid_q[31:0]),  .mixed(fmix_lo));
  riscv_crypto_aes_mixcol_fwd u_fmix_hi (.col(mid_q[63:32]), .mixed(fmix_hi));
  riscv_crypto_aes_mixcol_inv u_imix_lo (.col(mid_q[31:0]),  .mixed(imix_lo));
  riscv_crypto_aes_mixcol_inv u_imix_hi (.col(mid_q[63:32]), .mixed(imix_hi));

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sub_inv_q <= 1'b0;
      do_mix_q  <= 1'b0;
      mix_inv_q <= 1'b0;
      st_q      <= '0;
      mid_q     <= '0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sub_inv_q <= sub_inv_d;
      do_mix_q  <= do_mix_d;
      mix_inv_q <= mix_inv_d;
      st_q      <= st_d;
      mid_q     <= mid_d;
      rd_q      <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = !op_legal ? ST_DONE : (op_im ? ST_MIX : ST_SUB);
      ST_SUB:  if (last_k)   state_d = do_mix_q ? ST_MIX : ST_DONE;
      ST_MIX:  state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    cnt_d     = cnt_q;
    sub_inv_d = sub_inv_q;
    do_mix_d  = do_mix_q;
    mix_inv_d = mix_inv_q;
    st_d      = st_q;
    mid_d     = mid_q;
    rd_d      = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sub_inv_d = op_ds | op_dsm;
          do_mix_d  = op_esm | op_dsm | op_im;
          mix_inv_d = op_dsm | op_im;
          st_d      = {rs2, rs1};
          cnt_d     = '0;
          if (op_im) mid_d = rs1;
          if (!op_legal) rd_d = '0;
        end
      end
      ST_SUB: begin
        for (int unsigned i = 0; i < SBOX_PER_CYCLE; i++)
          mid_d[{lane_j[3*i +: 3], 3'b000} +: 8] = sb_out[8*i +: 8];
        cnt_d = cnt_q + 3'd1;
        if (last_k) begin
          cnt_d = '0;
          if (!do_mix_q) rd_d = mid_d;
        end
      end
      ST_MIX:  rd_d = mix_inv_q ? {imix_hi, imix_lo} : {fmix_hi, fmix_lo};
      default: ;
    endcase
    // rd keeps its last value across an abort; only the control state is dropped.
    if (flush) begin
      rd_d  = rd_q;
      cnt_d = '0;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    rd        = rd_q;
  end

endmodule

// File: tb/tb_riscv_crypto_fu_aes64_seq.sv
// Scoreboard bench for riscv_crypto_fu_aes64_seq: main unit with N=2 plus N=1/4/8
// instances for latency; FIPS-197 round-1 vectors.

module tb_riscv_crypto_fu_aes64_seq;

  localparam logic [4:0] OP_ES  = 5'b00001;
  localparam logic [4:0] OP_ESM = 5'b00010;
  localparam logic [4:0] OP_DS  = 5'b00100;
  localparam logic [4:0] OP_IM  = 5'b10000;

  localparam logic [63:0] A1     = 64'h2be2f4a0bee33d19;
  localparam logic [63:0] A2     = 64'h0848f8e92a8dc69a;
  localparam logic [63:0] ES_RD  = 64'hae52b4e0305dbfd4;
  localparam logic [63:0] ESM_RD = 64'h9a19cbe0e5816604;
  localparam logic [63:0] D2     = 64'he598271ef11141b8;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        op_es = 1'b0, op_esm = 1'b0, op_ds = 1'b0, op_dsm = 1'b0, op_im = 1'b0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic [3:0]  iv = '0;
  logic [3:0]  ir, ov;
  logic [3:0]  ov_prev = '0;
  logic [63:0] rdv [4];

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [1:0]  inst;
    logic [63:0] rd;
    int unsigned lat;
    int unsigned t0;
  } exp_t;
  exp_t sbq[$];

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) cyc <= cyc + 1;

  riscv_crypto_fu_aes64_seq #(.SBOX_PER_CYCLE(2)) u_dut_n2 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
    .op_es(op_es), .op_esm(op_esm), .op_ds(op_ds), .op_dsm(op_dsm), .op_im(op_im),
    .rs1(rs1), .rs2(rs2), .out_valid(ov[0]), .out_ready(out_ready), .rd(rdv[0]));

  riscv_crypto_fu_aes64_seq #(.SBOX_PER_CYCLE(1)) u_dut_n1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
    .op_es(op_es), .op_esm(op_esm), .op_ds(op_ds), .op_dsm(op_dsm), .op_im(op_im),
    .rs1(rs1), .rs2(rs2), .out_valid(ov[1]), .out_ready(1'b1), .rd(rdv[1]));

  riscv_crypto_fu_aes64_seq #(.SBOX_PER_CYCLE(4)) u_dut_n4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(iv[2]), .in_ready(ir[2]),
    .op_es(op_es), .op_esm(op_esm), .op_ds(op_ds), .op_dsm(op_dsm), .op_im(op_im),
    .rs1(rs1), .rs2(rs2), .out_valid(ov[2]), .out_ready(1'b1), .rd(rdv[2]));

  riscv_crypto_fu_aes64_seq #(.SBOX_PER_CYCLE(8)) u_dut_n8 (
    .g_clk(g_clk), .g_resetn(g_resetn), .flush(flush), .in_valid(iv[3]), .in_ready(ir[3]),
    .op_es(op_es), .op_esm(op_esm), .op_ds(op_ds), .op_dsm(op_dsm), .op_im(op_im),
    .rs1(rs1), .rs2(rs2), .out_valid(ov[3]), .out_ready(1'b1), .rd(rdv[3]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_op(input logic [4:0] o);
    {op_im, op_dsm, op_ds, op_esm, op_es} = o;
  endtask

  // Called at a falling edge; the request is accepted on the following rising edge.
  task automatic issue(input logic [1:0] inst, input logic [4:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp_rd,
                       input int unsigned lat, input bit track);
    exp_t e;
    check1("in_ready_before_issue", ir[inst], 1'b1);
    set_op(o);
    rs1 = a;
    rs2 = b;
    iv[inst] = 1'b1;
    if (track) begin
      e.inst = inst;
      e.rd   = exp_rd;
      e.lat  = lat;
      e.t0   = cyc;
      sbq.push_back(e);
    end
    @(negedge g_clk);
    iv = '0;
    set_op('0);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge g_clk);
      n++;
    end
    check("drain_pending", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic settle();
    repeat (2) @(negedge g_clk);
  endtask

  // Monitor: on each rising out_valid, pop the oldest expectation and compare.
  initial begin
    exp_t        e;
    int unsigned lat;
    forever begin
      @(negedge g_clk);
      for (int k = 0; k < 4; k++) begin
        if (g_resetn && ov[k] && !ov_prev[k]) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: inst %0d rd %h, expected no output", k, rdv[k]);
          end else begin
            e   = sbq.pop_front();
            lat = cyc - e.t0;
            check("result_inst", 64'(k), 64'(e.inst));
            check("rd", rdv[k], e.rd);
            check("latency", 64'(lat), 64'(e.lat));
          end
        end
      end
      ov_prev = ov;
    end
  end

  initial begin
    repeat (3) @(negedge g_clk);
    check1("reset_in_ready", ir[0], 1'b1);
    check1("reset_out_valid", ov[0], 1'b0);
    check("reset_rd", rdv[0], 64'd0);
    g_resetn = 1'b1;
    @(negedge g_clk);

    issue(2'd0, OP_ESM, A1, A2, ESM_RD, 6, 1'b1); drain(); settle();
    issue(2'd0, OP_ES,  A1, A2, ES_RD,  5, 1'b1); drain(); settle();
    issue(2'd0, OP_DS,  ES_RD, D2, A1,  5, 1'b1); drain(); settle();
    issue(2'd0, OP_IM,  ESM_RD, 64'd0, ES_RD, 2, 1'b1); drain(); settle();

    issue(2'd1, OP_ES, A1, A2, ES_RD, 9, 1'b1); drain(); settle();
    issue(2'd2, OP_ES, A1, A2, ES_RD, 3, 1'b1); drain(); settle();
    issue(2'd3, OP_ES, A1, A2, ES_RD, 2, 1'b1); drain(); settle();

    issue(2'd0, OP_ES | OP_IM, A1, A2, 64'd0, 1, 1'b1); drain(); settle();
    issue(2'd0, OP_ES, A1, A2, ES_RD, 5, 1'b1); drain(); settle();
    issue(2'd0, 5'b00000, A1, A2, 64'd0, 1, 1'b1); drain(); settle();

    // Back-pressure: DONE held, a new request is presented and must be ignored.
    out_ready = 1'b0;
    issue(2'd0, OP_ES, A1, A2, ES_RD, 5, 1'b1); drain();
    set_op(OP_IM);
    rs1 = ESM_RD;
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check1("bp_out_valid", ov[0], 1'b1);
      check("bp_rd", rdv[0], ES_RD);
      check1("bp_in_ready", ir[0], 1'b0);
      @(negedge g_clk);
    end
    iv[0] = 1'b0;
    set_op('0);
    out_ready = 1'b1;
    @(negedge g_clk);
    check1("bp_release_out_valid", ov[0], 1'b0);
    check1("bp_release_in_ready", ir[0], 1'b1);
    issue(2'd0, OP_ESM, A1, A2, ESM_RD, 6, 1'b1); drain(); settle();

    // Flush during the second SUB cycle.
    issue(2'd0, OP_ES, A1, A2, 64'd0, 0, 1'b0);
    @(negedge g_clk);
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check1("flush_sub_out_valid", ov[0], 1'b0);
    check1("flush_sub_in_ready", ir[0], 1'b1);
    repeat (8) @(negedge g_clk);
    issue(2'd0, OP_ES, A1, A2, ES_RD, 5, 1'b1); drain(); settle();

    // Flush coinciding with a request in IDLE discards it.
    flush = 1'b1;
    set_op(OP_ES);
    iv[0] = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    iv[0] = 1'b0;
    set_op('0);
    check1("flush_idle_in_ready", ir[0], 1'b1);
    repeat (8) @(negedge g_clk);
    check1("flush_idle_no_output", ov[0], 1'b0);

    // Flush while DONE is held.
    out_ready = 1'b0;
    issue(2'd0, OP_DS, ES_RD, D2, A1, 5, 1'b1); drain();
    flush = 1'b1;
    @(negedge g_clk);
    flush = 1'b0;
    check1("flush_done_out_valid", ov[0], 1'b0);
    check("flush_done_rd_kept", rdv[0], A1);
    check1("flush_done_in_ready", ir[0], 1'b1);
    out_ready = 1'b1;
    settle();

    // Asynchronous reset in the middle of SUB.
    issue(2'd0, OP_ESM, A1, A2, 64'd0, 0, 1'b0);
    @(negedge g_clk);
    g_resetn = 1'b0;
    #1;
    check1("rst_mid_out_valid", ov[0], 1'b0);
    check("rst_mid_rd", rdv[0], 64'd0);
    check1("rst_mid_in_ready", ir[0], 1'b1);
    @(negedge g_clk);
    g_resetn = 1'b1;
    repeat (10) @(negedge g_clk);
    check1("rst_mid_no_output", ov[0], 1'b0);

    issue(2'd0, OP_ES, A1, A2, ES_RD, 5, 1'b1); drain(); settle();

    check("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
